// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared helpers for the synchronous FIFO (pointer sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    // Ceiling log2 used to size address and pointer fields at elaboration.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_mem
// Description : Simple dual-port storage, synchronous write and synchronous
//               read on one clock. The array itself has no reset; only the
//               read output register can be cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       i_wr_en,
    input  logic [clog2(DEPTH)-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    input  logic [clog2(DEPTH)-1:0]    i_rd_addr,
    input  logic                       i_rd_clr,
    output logic [WIDTH-1:0]           o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data_q;

    // Write port: storage is never reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: output register with synchronous clear; holds when idle.
    always_ff @(posedge clk) begin
        if (i_rd_clr) begin
            r_rd_data_q <= '0;
        end else if (i_rd_en) begin
            r_rd_data_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data_q;

endmodule : sync_fifo_mem
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered read data and full/empty
//               flags derived from wrap-bit extended pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,     // active-high synchronous reset
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr_q;
    logic [PTR_W-1:0] r_rd_ptr_q;
    logic [PTR_W-1:0] w_wr_ptr_d;
    logic [PTR_W-1:0] w_rd_ptr_d;
    logic             w_wr_accept;
    logic             w_rd_accept;
    logic             w_full;
    logic             w_empty;

    // Flags come straight from the pointer registers, so outputs never
    // depend combinationally on the inputs.
    always_comb begin
        w_empty = (r_wr_ptr_q == r_rd_ptr_q);
        w_full  = (r_wr_ptr_q[ADDR_W-1:0] == r_rd_ptr_q[ADDR_W-1:0]) &&
                  (r_wr_ptr_q[ADDR_W] != r_rd_ptr_q[ADDR_W]);
    end

    // Accept qualification and next-pointer computation; reset masks both
    // requests so nothing is written or read in a reset cycle.
    always_comb begin
        w_wr_accept = wr_en && !w_full  && !rst_n;
        w_rd_accept = rd_en && !w_empty && !rst_n;
        w_wr_ptr_d  = r_wr_ptr_q;
        w_rd_ptr_d  = r_rd_ptr_q;
        if (w_wr_accept) begin
            w_wr_ptr_d = r_wr_ptr_q + PTR_W'(1);
        end
        if (w_rd_accept) begin
            w_rd_ptr_d = r_rd_ptr_q + PTR_W'(1);
        end
    end

    // Pointer registers; the wrap bit rolls over naturally at 2*DEPTH.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
        end
    end

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr_q[ADDR_W-1:0]),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_accept),
        .i_rd_addr (r_rd_ptr_q[ADDR_W-1:0]),
        .i_rd_clr  (rst_n),
        .o_rd_data (rd_data)
    );

    assign full  = w_full;
    assign empty = w_empty;

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo (DEPTH=16, WIDTH=8) using
//               a directed vector table plus hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       full;
    logic       empty;

    int n_checks;
    int n_errors;

    typedef struct {
        logic       rst;
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic [7:0] exp_rd;
        logic       exp_full;
        logic       exp_empty;
    } vec_t;

    vec_t vecs[$];

    sync_fifo #(
        .DEPTH (16),
        .WIDTH (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic we, input logic [7:0] wd,
                       input logic re, input logic [7:0] erd,
                       input logic ef, input logic ee);
        vec_t v;
        v.rst = r; v.we = we; v.wd = wd; v.re = re;
        v.exp_rd = erd; v.exp_full = ef; v.exp_empty = ee;
        vecs.push_back(v);
    endtask

    // Apply one cycle of inputs and advance to just after the next edge.
    task automatic step(input logic r, input logic we, input logic [7:0] wd,
                        input logic re);
        rst_n   = r;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] erd,
                         input logic ef, input logic ee);
        n_checks++;
        if (rd_data !== erd || full !== ef || empty !== ee) begin
            n_errors++;
            $display("FAIL %s: rd_data=%h full=%b empty=%b, expected rd_data=%h full=%b empty=%b",
                     name, rd_data, full, empty, erd, ef, ee);
        end
    endtask

    initial begin
        logic [7:0] model[$];
        logic [7:0] exp;

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;

        // ---------------- vector table ----------------
        // reset held two edges, then reads on empty keep rd_data at 0
        add(1, 0, 8'h00, 0, 8'h00, 0, 1);
        add(1, 0, 8'h00, 0, 8'h00, 0, 1);
        add(0, 0, 8'h00, 1, 8'h00, 0, 1);
        add(0, 0, 8'h00, 1, 8'h00, 0, 1);
        add(0, 0, 8'h00, 1, 8'h00, 0, 1);
        // basic order
        add(0, 1, 8'h24, 0, 8'h00, 0, 0);
        add(0, 1, 8'h81, 0, 8'h00, 0, 0);
        add(0, 1, 8'h09, 0, 8'h00, 0, 0);
        add(0, 1, 8'h63, 0, 8'h00, 0, 0);
        add(0, 1, 8'h0D, 0, 8'h00, 0, 0);
        add(0, 0, 8'h00, 1, 8'h24, 0, 0);
        add(0, 0, 8'h00, 1, 8'h81, 0, 0);
        add(0, 0, 8'h00, 1, 8'h09, 0, 0);
        add(0, 0, 8'h00, 1, 8'h63, 0, 0);
        add(0, 0, 8'h00, 1, 8'h0D, 0, 1);
        // underflow: rd_data holds last value
        add(0, 0, 8'h00, 1, 8'h0D, 0, 1);
        add(0, 0, 8'h00, 1, 8'h0D, 0, 1);
        add(0, 0, 8'h00, 1, 8'h0D, 0, 1);
        add(0, 0, 8'h00, 1, 8'h0D, 0, 1);
        add(0, 1, 8'h5A, 0, 8'h0D, 0, 0);
        add(0, 0, 8'h00, 1, 8'h5A, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].re);
            check($sformatf("vec%0d", i), vecs[i].exp_rd,
                  vecs[i].exp_full, vecs[i].exp_empty);
        end

        // ---------------- fill / overflow ----------------
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'(i), 0);
            check($sformatf("fill%0d", i), 8'h5A, (i == 15), 1'b0);
        end
        step(0, 1, 8'hAA, 0);
        check("overflow_drop", 8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 8'h00, 1);
            check($sformatf("drain%0d", i), 8'(i), 1'b0, (i == 15));
        end
        step(0, 0, 8'h00, 1);
        check("drain_extra", 8'h0F, 1'b0, 1'b1);

        // ---------------- simultaneous read/write ----------------
        step(0, 1, 8'h11, 0); check("pre0", 8'h0F, 1'b0, 1'b0);
        step(0, 1, 8'h22, 0); check("pre1", 8'h0F, 1'b0, 1'b0);
        step(0, 1, 8'h33, 0); check("pre2", 8'h0F, 1'b0, 1'b0);
        model = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 20; i++) begin
            exp = model.pop_front();
            model.push_back(8'(8'h40 + i));
            step(0, 1, 8'(8'h40 + i), 1);
            check($sformatf("both%0d", i), exp, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            exp = model.pop_front();
            step(0, 0, 8'h00, 1);
            check($sformatf("tail%0d", i), exp, 1'b0, (i == 2));
        end

        // full + both: only the read is taken
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'(8'h80 + i), 0);
        end
        check("refill_full", 8'h53, 1'b1, 1'b0);
        step(0, 1, 8'hEE, 1);
        check("full_both", 8'h80, 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            step(0, 0, 8'h00, 1);
            check($sformatf("full_drain%0d", i), 8'(8'h80 + i), 1'b0, (i == 15));
        end

        // empty + both: only the write is taken, no bypass
        step(0, 1, 8'h77, 1);
        check("empty_both", 8'h8F, 1'b0, 1'b0);
        step(0, 0, 8'h00, 1);
        check("empty_both_read", 8'h77, 1'b0, 1'b1);

        // ---------------- mid-operation reset ----------------
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 8'(8'hC0 + i), 0);
        end
        check("preload6", 8'h77, 1'b0, 1'b0);
        step(1, 1, 8'hFF, 1);
        check("midop_reset", 8'h00, 1'b0, 1'b1);
        step(0, 1, 8'h3C, 0);
        check("post_reset_wr", 8'h00, 1'b0, 1'b0);
        step(0, 0, 8'h00, 1);
        check("post_reset_rd", 8'h3C, 1'b0, 1'b1);
        step(0, 0, 8'h00, 1);
        check("post_reset_underflow", 8'h3C, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sync_fifo
`default_nettype wire

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, first-in first-out buffer with a registered read port and full/empty status flags.
- Decouples a producer and a consumer in the same clock domain, e.g. between a datapath stage and a bus interface.
- Storage is DEPTH entries of WIDTH bits.
- Writes and reads are qualified by their enables and are silently ignored when they cannot be accepted.

Parameters:
- DEPTH, 16, number of entries; must be a power of two and at least 2.
- WIDTH, 8, data word width in bits.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous, active-high reset. Asserted when 1, despite the suffix; sampled on the rising edge of clk.
- wr_en  input  1  write request.
- wr_data  input  WIDTH  data to write.
- rd_en  input  1  read request.
- rd_data  output  WIDTH  registered read data.
- full  output  1  high when DEPTH entries are stored.
- empty  output  1  high when 0 entries are stored.

Behaviour:
- Internal pointers: wr_ptr and rd_ptr, each log2(DEPTH)+1 bits. The low bits address storage; the MSB is the wrap bit.
- Flags:
  - empty = (wr_ptr == rd_ptr).
  - full = (addresses equal) && (wrap bits differ).
  - Both are combinational from the pointer registers, so they update in the cycle after the accepting edge.
- Reset, at a clock edge with rst_n = 1:
  - wr_ptr = 0, rd_ptr = 0, rd_data = 0, so empty = 1 and full = 0.
  - Storage contents are not cleared.
  - A reset mid-operation discards all stored data; any wr_en or rd_en in that cycle is ignored.
  - Reset has priority over everything else.
- Write accept: on a rising edge with wr_en = 1 and full = 0:
  - mem[wr_ptr addr] <= wr_data.
  - wr_ptr increments and wraps modulo 2*DEPTH.
- Read accept: on a rising edge with rd_en = 1 and empty = 0:
  - rd_data <= mem[rd_ptr addr]; the value is visible after that edge, giving one-cycle latency.
  - rd_ptr increments.
- rd_data holds its last value when no read is accepted.
- There is no first-word fall-through.
- Overflow (wr_en while full): write is dropped; no state change; no error flag.
- Underflow (rd_en while empty): read is dropped; rd_data and pointers are unchanged.
- Simultaneous wr_en and rd_en:
  - Not full and not empty: both are accepted; occupancy is unchanged.
  - When empty: only the write is accepted; the read is ignored and the new word is not bypassed to rd_data.
  - When full: only the read is accepted; the write is dropped.
- Pointer wrap is seamless: after 2*DEPTH accepted operations the pointers return to 0 with ordering preserved.
- FIFO order is strict: words are read in exactly the order they were accepted.
- No combinational path exists from inputs to outputs.

Decomposition:
- Package sync_fifo_pkg: function for ceiling log2; localparam-derived ADDR_W = log2(DEPTH) and PTR_W = ADDR_W+1 are computed inside the module from that function.
- One natural sub-module: sync_fifo_mem. It is a simple dual-port array with a synchronous write port and a synchronous read port on one clock, with no reset on storage. It is parameterised by DEPTH and WIDTH and is inferable as block or distributed RAM.
- The top level holds the pointers, flag logic and accept qualification.

Test Plan:
- Reset: hold rst_n=1 for 2 edges, then release → empty=1, full=0, rd_data=0x00; rd_en=1 for 3 cycles leaves rd_data=0x00 and empty=1.
- Basic order: write 0x24,0x81,0x09,0x63,0x0D on 5 consecutive edges, then read 5 → rd_data returns 0x24,0x81,0x09,0x63,0x0D, one cycle after each accepting edge; empty=1 after the 5th read.
- Fill/overflow: write 0x00..0x0F (16 words) → full=1 after the 16th edge; a 17th write of 0xAA is dropped; reading 16 returns 0x00..0x0F, never 0xAA.
- Underflow: from empty, assert rd_en for 4 cycles → pointers and rd_data unchanged; a subsequent write of 0x5A then read returns 0x5A.
- Simultaneous: preload 3 words (0x11,0x22,0x33), then assert wr_en and rd_en together for 20 cycles with an incrementing pattern from 0x40 → occupancy stays 3 and outputs are 0x11,0x22,0x33,0x40,... in order, exercising pointer wrap. Also check full+both → only the read is taken, and empty+both → only the write is taken.
- Mid-op reset: write 6 words, assert rst_n=1 for one edge together with wr_en=1 → empty=1, rd_data=0; the next write/read pair returns only the post-reset word.
